// File: rtl/id_inst_buffer.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of {inst, pc, pc4, imm, zimm}
// with load-use hold of the head entry and single-cycle flush.
module id_inst_buffer #(
    parameter int         DEPTH   = 4,
    parameter int         XLEN    = 32,
    parameter logic [1:0] WB_LOAD = 2'b01
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          in_inst_i,
    input  logic [XLEN-1:0]          in_pc_i,
    input  logic [XLEN-1:0]          in_pc4_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_inst_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_pc4_o,
    output logic [XLEN-1:0]          out_imm_o,
    output logic [XLEN-1:0]          out_zimm_o,
    input  logic [4:0]               ex_rd_i,
    input  logic [1:0]               ex_wb_sel_i,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
        logic [4:0]      zimm;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic signed [31:0] imm32;
    entry_t          new_entry;
    entry_t          head;
    logic [6:0]      head_opc;
    logic [2:0]      head_funct3;
    logic [4:0]      head_rs1;
    logic [4:0]      head_rs2;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hz;
    logic            push;
    logic            pop;

    // Immediate decode happens on the incoming word so decode only reads stored values.
    always_comb begin
        imm32 = '0;
        case (in_inst_i[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm32 = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
            OPC_STORE:
                imm32 = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
            OPC_BRANCH:
                imm32 = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7],
                         in_inst_i[30:25], in_inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {in_inst_i[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12],
                         in_inst_i[20], in_inst_i[30:21], 1'b0};
            OPC_SYSTEM:
                imm32 = {20'b0, in_inst_i[31:20]};
            default:
                imm32 = '0;
        endcase
    end

    always_comb begin
        new_entry      = '0;
        new_entry.inst = in_inst_i;
        new_entry.pc   = in_pc_i;
        new_entry.pc4  = in_pc4_i;
        new_entry.imm  = XLEN'(imm32);
        new_entry.zimm = in_inst_i[19:15];
    end

    assign head        = mem_q[rd_ptr_q];
    assign head_opc    = head.inst[6:0];
    assign head_funct3 = head.inst[14:12];
    assign head_rs1    = head.inst[19:15];
    assign head_rs2    = head.inst[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (head_opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                uses_rs1 = 1'b1;
            OPC_SYSTEM:
                uses_rs1 = ~head_funct3[2];
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    assign hz = (count_q != '0) && (ex_wb_sel_i == WB_LOAD) && (ex_rd_i != 5'd0) &&
                ((uses_rs1 && (head_rs1 == ex_rd_i)) || (uses_rs2 && (head_rs2 == ex_rd_i)));

    // in_ready_o depends only on registered occupancy, so a full buffer refuses even with a pop.
    assign in_ready_o  = (count_q != CW'(DEPTH));
    assign out_valid_o = (count_q != '0) && !hz;
    assign stall_o     = hz;
    assign count_o     = count_q;

    assign out_inst_o  = head.inst;
    assign out_pc_o    = head.pc;
    assign out_pc4_o   = head.pc4;
    assign out_imm_o   = head.imm;
    assign out_zimm_o  = {{(XLEN-5){1'b0}}, head.zimm};

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
